// File: rtl/bench_uart_pkg.sv
// Shared definitions for the benchmark-result UART serializer.
//
// Contents:
//   state_t         - transmitter FSM states
//   HDR_MAGIC       - upper five bits of every header byte
//   BITS_PER_BYTE   - data bits carried per UART frame
//   frame_cycles()  - clock cycles one whole two-byte packet keeps the line busy
package bench_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE
   } state_t;

   localparam logic [4:0] HDR_MAGIC     = 5'b10100;
   localparam int         BITS_PER_BYTE = 8;

   // A byte frame is start + data + optional parity + stop, and a packet is
   // always two frames (header then payload) sent back to back.
   function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                                input bit          parity_en);
      return 2 * (BITS_PER_BYTE + 2 + (parity_en ? 1 : 0)) * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud-rate down-counter that measures out one serial bit period.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   load     in   restart the bit period (counter reloads to CLKS_PER_BIT-1)
//   bit_end  out  high in the last cycle of the current bit period
//
// With CLKS_PER_BIT=1 the counter sits at zero, so every cycle is a bit end.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   output logic bit_end
);

   localparam int unsigned      CNT_W  = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   // Count down from the reload value and park at zero; the owner reloads
   // on every state entry so each bit gets exactly CLKS_PER_BIT cycles.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= RELOAD;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   // Reaching zero marks the final cycle of the bit.
   assign bit_end = (count == '0);

endmodule

// File: rtl/bench_result_uart_tx.sv
// Serializes a {selector, result} snapshot from the benchmark wrapper as a
// two-byte UART packet on a single pin: header {HDR_MAGIC, sel} then payload.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   data_in  in   [7:0] result byte from the wrapper output mux
//   sel_in   in   [2:0] selector that chose data_in
//   send     in   manual trigger, rising edge only
//   auto_en  in   also trigger whenever {sel_in, data_in} differs from last packet
//   tx       out  serial line, idles high
//   busy     out  high while a packet is in flight
//   done     out  one-cycle pulse when a packet completes
module bench_result_uart_tx
   import bench_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter bit          PARITY_EN    = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] data_in,
   input  logic [2:0] sel_in,
   input  logic       send,
   input  logic       auto_en,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   state_t      state;
   logic        send_q;
   logic        snap_valid;
   logic [10:0] last_snap;
   logic [10:0] snap;
   logic [7:0]  pay_byte;
   logic [7:0]  cur_byte;
   logic [7:0]  shift_reg;
   logic [2:0]  bit_idx;
   logic        byte_idx;
   logic        trigger;
   logic        in_bit_state;
   logic        bit_end;
   logic        timer_load;

   // A packet is requested by a fresh send edge, or in auto mode by a
   // snapshot that has never been sent or differs from the last one sent.
   // The FSM only honours this in IDLE; a pending auto change therefore
   // simply waits, while a send edge seen during a packet is lost because
   // send_q keeps tracking send throughout.
   assign snap    = {sel_in, data_in};
   assign trigger = (send & ~send_q) |
                    (auto_en & (~snap_valid | (snap != last_snap)));

   // Every bit-carrying state is timed by the shared baud counter, which is
   // reloaded on entry into each such state (and on leaving IDLE).
   assign in_bit_state = (state == START) || (state == DATA) ||
                         (state == PARITY) || (state == STOP);
   assign timer_load   = ((state == IDLE) && trigger) || (in_bit_state && bit_end);

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (timer_load),
      .bit_end (bit_end)
   );

   // Transmit FSM. tx, busy and done are registered and are always set on
   // the same edge that enters a state, so the line level for each bit is
   // present for the whole of that state. The header is loaded first; after
   // its stop bit the payload is swapped in and the FSM goes straight back
   // to START without any idle gap between the two bytes.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         tx         <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         send_q     <= 1'b0;
         snap_valid <= 1'b0;
         last_snap  <= '0;
         pay_byte   <= '0;
         cur_byte   <= '0;
         shift_reg  <= '0;
         bit_idx    <= '0;
         byte_idx   <= 1'b0;
      end else begin
         send_q <= send;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  cur_byte   <= {HDR_MAGIC, sel_in};
                  shift_reg  <= {HDR_MAGIC, sel_in};
                  pay_byte   <= data_in;
                  last_snap  <= snap;
                  snap_valid <= 1'b1;
                  byte_idx   <= 1'b0;
                  busy       <= 1'b1;
                  tx         <= 1'b0;
                  state      <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  tx      <= shift_reg[0];
                  bit_idx <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'(BITS_PER_BYTE - 1)) begin
                     if (PARITY_EN) begin
                        tx    <= ^cur_byte;
                        state <= PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     shift_reg <= shift_reg >> 1;
                     tx        <= shift_reg[1];
                     bit_idx   <= bit_idx + 3'd1;
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  tx    <= 1'b1;
                  state <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (!byte_idx) begin
                     byte_idx  <= 1'b1;
                     cur_byte  <= pay_byte;
                     shift_reg <= pay_byte;
                     tx        <= 1'b0;
                     state     <= START;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     tx    <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/bench_result_uart_tx.md
Name: bench_result_uart_tx

Overview:
Downstream serializer for the benchmark wrapper's 8-bit selected result byte and its 3-bit selector. It captures a {selector, result} snapshot and transmits it as a two-byte, UART-framed packet on one pin: a header byte, then a payload byte. Off-chip logging of benchmark outputs then needs only a single io pin instead of all eight.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..255.
PARITY_EN, 0, 1 inserts an even-parity bit after each byte's 8 data bits.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  synchronous, active-low reset.
data_in  input  8  result byte from the wrapper output mux.
sel_in  input  3  selector value that chose data_in.
send  input  1  manual trigger; only the rising edge is used.
auto_en  input  1  when 1, a change in {sel_in, data_in} also triggers a packet.
tx  output  1  serial line; idles high.
busy  output  1  high while a packet is in flight.
done  output  1  one-cycle pulse at the end of a packet.

Behaviour:
- Reset (reset_n=0 at a clk edge): tx=1, busy=0, done=0, FSM to IDLE, send_q=0, snap_valid=0. Applies mid-packet; the line returns high on that edge.
- Trigger is evaluated only in IDLE. It fires on (send & ~send_q), or on auto_en & (~snap_valid | {sel_in,data_in} != last_snap).
- Both trigger sources in the same cycle produce one packet.
- A send rising edge while busy is dropped.
- An auto change while busy is not dropped; it is re-evaluated on return to IDLE.
- On trigger edge, the block latches hdr = {5'b10100, sel_in} and pay = data_in, and sets last_snap = {sel_in,data_in} and snap_valid=1. From the next cycle: busy=1 and tx drives the start bit.
- FSM states: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> START (second byte) or DONE.
- Every bit state lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads on each state entry.
- START: tx=0.
- DATA: 8 bits, LSB first, 3-bit index, shifting a copy of the current byte.
- PARITY: tx = XOR of the 8 data bits.
- STOP: tx=1.
- Byte index 0 = hdr, 1 = pay. After STOP of byte 0, go directly to START of byte 1; there is no inter-byte idle.
- DONE lasts one cycle: done=1, busy=0, tx=1, then IDLE. A new trigger is accepted no earlier than the IDLE cycle after DONE.
- Busy duration = 2*(10+PARITY_EN)*CLKS_PER_BIT cycles. With defaults: 80 cycles.
- Inputs may change while busy without affecting the packet in flight.
- The baud counter is $clog2(CLKS_PER_BIT+1) bits wide and counts CLKS_PER_BIT-1 down to 0. CLKS_PER_BIT=1 gives one cycle per bit.

Decomposition:
- Package bench_uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, DONE)
  - HDR_MAGIC = 5'b10100
  - BITS_PER_BYTE = 8
  - helper function for frame length
- One sub-module, uart_bit_timer: a parameterised CLKS_PER_BIT down-counter with load input and bit_end pulse output, also using synchronous active-low reset. It is reused by the team's later RX block.

Test Plan:
- Reset, then sel_in=3'b101, data_in=8'h5A, send pulsed high for 1 cycle -> busy rises on the next cycle for 80 cycles.
  - Byte 1 on tx: start 0, bits 1,0,1,0,0,1,0,1 (0xA5), stop 1.
  - Byte 2: start 0, bits 0,1,0,1,1,0,1,0 (0x5A), stop 1.
  - Then done=1 for one cycle.
- Hold send high for 200 cycles -> exactly one packet.
- Re-pulse send at cycle 30 of a packet -> ignored; no second packet.
- auto_en=1 with data_in stepping 8'h00 -> 8'h01 mid-packet -> the current packet is unchanged, and a second packet with payload 0x01 starts within 2 cycles of done.
- PARITY_EN=1, CLKS_PER_BIT=1, data 8'h07, sel 3'b000 -> header 0xA0 with parity bit 0, payload with parity bit 1; busy for 22 cycles.
- reset_n low for 1 cycle at cycle 40 of a packet -> tx=1, busy=0 after that edge; no done pulse.
- auto_en=1 after reset with constant inputs -> exactly one packet, then idle.
